reduce_tree_pipe: RTL and testbench
===================================

Name: reduce_tree_pipe

Overview:
- Parametrised, pipelined bit-reduction unit. Collapses a WIDTH-bit operand to one bit by a binary tree of 2-input gates.
- The reduction op is selectable per operand: OR, AND, XOR or NOR (zero detect).
- Register stages are inserted every LEVELS_PER_STAGE tree levels, with a valid/ready handshake and backpressure.
- Serves ALU zero/flag detection and bne/blt condition evaluation in the processor datapath at higher clock rates.

Parameters:
- WIDTH, 32, operand width; power of two, 2..64.
- LEVELS_PER_STAGE, 1, tree levels between pipeline registers; 1..log2(WIDTH).
- Derived: LOG2W = log2(WIDTH); NSTAGE = ceil(LOG2W / LEVELS_PER_STAGE). Default gives 5.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand present.
- in_ready  output  1  unit can accept an operand this cycle.
- in_data  input  WIDTH  operand.
- in_mode  input  2  operation select: 00 OR, 01 AND, 10 XOR, 11 NOR.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result this cycle.
- out_bit  output  1  reduction result.
- out_mode  output  2  mode that produced out_bit.

Behaviour:
- Tree structure:
  - Level k (k = 1..LOG2W) combines adjacent pairs of level k-1: node[i] = f(prev[2i], prev[2i+1]).
  - f is AND for mode 01, XOR for mode 10, and OR for modes 00 and 11.
  - Mode 11 inverts the final root value only, never intermediate nodes.
- Pipeline registers:
  - Stage s (s = 0..NSTAGE-1) holds the partial vector after min((s+1)*LEVELS_PER_STAGE, LOG2W) levels, plus its mode and a valid bit.
  - The last stage holds the 1-bit result (already inverted for NOR) and drives out_bit, out_mode and out_valid directly.
- Stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall. This is combinational; it does not depend on in_valid.
- Advance: when stall is 0, every stage loads from its predecessor on the clock edge.
  - Stage 0 loads valid = in_valid and data/mode from the inputs.
  - The input is accepted when in_valid & in_ready.
- Hold: when stall is 1, all stages (valid, data, mode) hold their values. in_data is ignored.
- Bubbles are not collapsed. An empty stage still advances only in lockstep with the others.
- Latency and throughput:
  - An accepted operand appears at out_valid exactly NSTAGE cycles after acceptance, plus the number of stall cycles in between.
  - Throughput is one result per cycle when out_ready is held high.
- Ordering: results emerge strictly in acceptance order. out_mode always matches the mode accepted with that operand.
- Reset:
  - On a clock edge with reset = 1, all stage valid bits, partial data, modes, out_bit and out_mode become 0. Therefore out_valid = 0 and in_ready = 1 in the cycle after reset.
  - Reset overrides stall and in_valid. In-flight operands are discarded and never emitted.
- Gating rules:
  - out_bit and out_mode are don't-care to the consumer while out_valid = 0, but they must be 0 after reset until the first result.
  - Invalid stages do not need to be zeroed while advancing.
- Edge cases:
  - WIDTH = 2 gives one level, so NSTAGE = 1.
  - LEVELS_PER_STAGE >= LOG2W gives a single register stage, with the whole tree combinational before it.
- No X propagation: in_data bits are never left unconnected, and all registers are reset.

Test Plan:
- Modes on WIDTH=32, LPS=1:
  - Mode 00, in_data 0x00000000 -> out_bit 0, out_valid high exactly 5 cycles after acceptance.
  - Mode 00, 0x00010000 -> 1.
  - Mode 11, 0x00000000 -> 1.
  - Mode 11, 0x80000000 -> 0.
  - Mode 01, 0xFFFFFFFF -> 1.
  - Mode 01, 0xFFFFFFFE -> 0.
  - Mode 10, 0x80000001 -> 0.
  - Mode 10, 0x80000000 -> 1.
  - Mode 10, 0x00000007 -> 1.
- Streaming: 8 back-to-back operands with mixed modes and out_ready held 1 -> 8 consecutive out_valid cycles starting cycle 5, correct out_bit/out_mode order, in_ready never drops.
- Backpressure: with a result at the output, drop out_ready for 3 cycles -> out_bit/out_mode/out_valid stable, in_ready 0 for those 3 cycles, no operand lost or duplicated after release.
- Reset mid-flight: accept 3 operands, assert reset for 1 cycle at cycle 2 -> out_valid 0 and out_bit 0 next cycle, none of the 3 results ever appear, in_ready 1.
- Parameter sweep:
  - WIDTH=8, LPS=2 -> latency 2 cycles.
  - WIDTH=64, LPS=6 -> latency 1.
  - WIDTH=2, LPS=1 -> latency 1.
  - Each with 200 random operands/modes checked against a behavioural reduction model.
- Bubble behaviour: in_valid toggling 1,0,1 with out_ready 1 -> out_valid pattern 1,0,1 delayed by NSTAGE cycles.

Source files
------------

// File: rtl/reduce_tree_pipe_if.sv
// reduce_tree_pipe_if: operand/result handshake bundle for the pipelined reduction unit
interface reduce_tree_pipe_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic [1:0]       out_mode;
  modport master (output in_valid, in_data, in_mode, out_ready,
                  input  in_ready, out_valid, out_bit, out_mode);
  modport slave  (input  in_valid, in_data, in_mode, out_ready,
                  output in_ready, out_valid, out_bit, out_mode);
endinterface

// File: rtl/reduce_tree_pipe.sv
// reduce_tree_pipe: pipelined OR/AND/XOR/NOR bit-reduction tree with valid/ready backpressure
module reduce_tree_pipe #(
  parameter int WIDTH            = 32,
  parameter int LEVELS_PER_STAGE = 1
) (
  input logic               clock,
  input logic               reset,
  reduce_tree_pipe_if.slave bus
);
  localparam int LOG2W  = $clog2(WIDTH);
  localparam int NSTAGE = (LOG2W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
  logic stall;
  assign stall        = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign bus.out_valid = g_st[NSTAGE-1].valid_q;
  assign bus.out_bit   = g_st[NSTAGE-1].data_q[0];
  assign bus.out_mode  = g_st[NSTAGE-1].mode_q;
  for (genvar s = 0; s < NSTAGE; s++) begin : g_st
    localparam int  LIN  = s * LEVELS_PER_STAGE;
    localparam int  LOUT = ((s + 1) * LEVELS_PER_STAGE < LOG2W) ? (s + 1) * LEVELS_PER_STAGE : LOG2W;
    localparam int  NL   = LOUT - LIN;
    localparam int  WI   = WIDTH >> LIN;
    localparam int  WO   = WIDTH >> LOUT;
    localparam bit  LAST = (s == NSTAGE - 1);
    logic [WI-1:0] src;
    logic [1:0]    src_mode;
    logic          src_valid;
    logic [WO-1:0] root;
    logic [WO-1:0] data_d, data_q;
    logic [1:0]    mode_d, mode_q;
    logic          valid_d, valid_q;
    if (s == 0) begin : g_in
      assign src       = bus.in_data;
      assign src_mode  = bus.in_mode;
      assign src_valid = bus.in_valid;
    end else begin : g_prev
      assign src       = g_st[s-1].data_q;
      assign src_mode  = g_st[s-1].mode_q;
      assign src_valid = g_st[s-1].valid_q;
    end
    // NOR shares the OR tree; only the final root is inverted
    for (genvar l = 1; l <= NL; l++) begin : g_lv
      localparam int PW = WI >> (l - 1);
      logic [PW-1:0]   p;
      logic [PW/2-1:0] v;
      if (l == 1) begin : g_src
        assign p = src;
      end else begin : g_prv
        assign p = g_lv[l-1].v;
      end
      for (genvar i = 0; i < PW / 2; i++) begin : g_n
        assign v[i] = (src_mode == 2'b01) ? p[2*i] & p[2*i+1] :
                      (src_mode == 2'b10) ? p[2*i] ^ p[2*i+1] : p[2*i] | p[2*i+1];
      end
    end
    assign root = g_lv[NL].v;
    always_comb begin
      data_d  = stall ? data_q : (LAST && src_mode == 2'b11) ? ~root : root;
      mode_d  = stall ? mode_q : src_mode;
      valid_d = stall ? valid_q : src_valid;
    end
    always_ff @(posedge clock) begin
      if (reset) begin
        data_q  <= '0;
        mode_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        mode_q  <= mode_d;
        valid_q <= valid_d;
      end
    end
  end
endmodule

// File: tb/tb_reduce_tree_pipe.sv
// tb_reduce_tree_pipe: scenario tasks against a reference reduction model on four parameterisations
module tb_reduce_tree_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  reduce_tree_pipe_if #(.WIDTH(32)) if0 ();
  reduce_tree_pipe_if #(.WIDTH(8))  if1 ();
  reduce_tree_pipe_if #(.WIDTH(64)) if2 ();
  reduce_tree_pipe_if #(.WIDTH(2))  if3 ();
  reduce_tree_pipe #(.WIDTH(32), .LEVELS_PER_STAGE(1)) u0 (.clock(clk), .reset(rst), .bus(if0));
  reduce_tree_pipe #(.WIDTH(8),  .LEVELS_PER_STAGE(2)) u1 (.clock(clk), .reset(rst), .bus(if1));
  reduce_tree_pipe #(.WIDTH(64), .LEVELS_PER_STAGE(6)) u2 (.clock(clk), .reset(rst), .bus(if2));
  reduce_tree_pipe #(.WIDTH(2),  .LEVELS_PER_STAGE(1)) u3 (.clock(clk), .reset(rst), .bus(if3));
  int n_chk = 0;
  int n_fail = 0;
  function automatic logic ref_bit(input logic [63:0] d, input int w, input logic [1:0] m);
    logic [63:0] mask;
    logic [63:0] x;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    x = d & mask;
    case (m)
      2'd0:    return x != 64'd0;
      2'd1:    return x == mask;
      2'd2:    return ($countones(x) % 2) == 1;
      default: return x == 64'd0;
    endcase
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    if0.in_valid = 0; if0.in_data = '0; if0.in_mode = 0; if0.out_ready = 1;
    if1.in_valid = 0; if1.in_data = '0; if1.in_mode = 0; if1.out_ready = 1;
    if2.in_valid = 0; if2.in_data = '0; if2.in_mode = 0; if2.out_ready = 1;
    if3.in_valid = 0; if3.in_data = '0; if3.in_mode = 0; if3.out_ready = 1;
  endtask
  task automatic test_reset();
    logic [4:0] o [4];
    rst = 1;
    idle();
    repeat (2) step();
    rst = 0;
    o = '{{if0.out_valid, if0.out_bit, if0.out_mode, if0.in_ready},
          {if1.out_valid, if1.out_bit, if1.out_mode, if1.in_ready},
          {if2.out_valid, if2.out_bit, if2.out_mode, if2.in_ready},
          {if3.out_valid, if3.out_bit, if3.out_mode, if3.in_ready}};
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (o[k] !== 5'b00001) begin
        n_fail++;
        $display("FAIL reset[u%0d]: {valid,bit,mode,in_ready}=%b required 00001", k, o[k]);
      end
    end
  endtask
  task automatic test_modes();
    logic [1:0]  mt [9] = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    logic [31:0] dt [9] = '{32'h00000000, 32'h00010000, 32'h00000000, 32'h80000000,
                           32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000001, 32'h80000000, 32'h00000007};
    logic        et [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int n;
    for (int k = 0; k < 9; k++) begin
      if0.in_valid = 1; if0.in_data = dt[k]; if0.in_mode = mt[k];
      step();
      if0.in_valid = 0;
      n = 1;
      while (!if0.out_valid && n < 20) begin
        step();
        n++;
      end
      n_chk++;
      if (n !== 5 || if0.out_bit !== et[k] || if0.out_mode !== mt[k]) begin
        n_fail++;
        $display("FAIL modes[%0d]: latency=%0d bit=%b mode=%0d, required latency=5 bit=%b mode=%0d",
                 k, n, if0.out_bit, if0.out_mode, et[k], mt[k]);
      end
      step();
      n_chk++;
      if (if0.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL modes_single[%0d]: out_valid=%b required 0", k, if0.out_valid);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [31:0] d [8];
    logic [1:0]  m [8];
    logic ev, eb;
    logic [1:0] em;
    for (int k = 0; k < 8; k++) begin
      d[k] = $urandom;
      m[k] = 2'(k % 4);
    end
    for (int c = 0; c < 18; c++) begin
      if0.in_valid = (c < 8);
      if (c < 8) begin
        if0.in_data = d[c];
        if0.in_mode = m[c];
      end
      n_chk++;
      if (if0.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_in_ready[c%0d]: got %b required 1", c, if0.in_ready);
      end
      step();
      ev = (c - 4 >= 0) && (c - 4 < 8);
      eb = 1'b0;
      em = 2'd0;
      if (ev) begin
        eb = ref_bit({32'd0, d[c-4]}, 32, m[c-4]);
        em = m[c-4];
      end
      n_chk++;
      if (if0.out_valid !== ev || (ev && (if0.out_bit !== eb || if0.out_mode !== em))) begin
        n_fail++;
        $display("FAIL b2b[c%0d]: valid=%b bit=%b mode=%0d, required valid=%b bit=%b mode=%0d",
                 c + 1, if0.out_valid, if0.out_bit, if0.out_mode, ev, eb, em);
      end
    end
  endtask
  task automatic test_backpressure();
    logic [31:0] d [4];
    logic [1:0]  m [4];
    logic        e [4];
    int q;
    for (int k = 0; k < 4; k++) begin
      d[k] = $urandom;
      m[k] = 2'($urandom_range(0, 3));
      e[k] = ref_bit({32'd0, d[k]}, 32, m[k]);
      if0.in_valid = 1; if0.in_data = d[k]; if0.in_mode = m[k];
      step();
    end
    if0.in_valid = 0;
    step();
    for (int k = 0; k < 3; k++) begin
      if0.out_ready = 0;
      if0.in_valid = 1;
      if0.in_data = $urandom;
      if0.in_mode = 2'($urandom_range(0, 3));
      #1;
      n_chk++;
      if (if0.in_ready !== 1'b0 || if0.out_valid !== 1'b1 || if0.out_bit !== e[0] || if0.out_mode !== m[0]) begin
        n_fail++;
        $display("FAIL stall[%0d]: in_ready=%b valid=%b bit=%b mode=%0d, required 0 1 %b %0d",
                 k, if0.in_ready, if0.out_valid, if0.out_bit, if0.out_mode, e[0], m[0]);
      end
      step();
    end
    if0.out_ready = 1;
    if0.in_valid = 0;
    q = 0;
    for (int c = 0; c < 12; c++) begin
      if (if0.out_valid) begin
        n_chk++;
        if (q >= 4) begin
          n_fail++;
          $display("FAIL bp_extra: unexpected result bit=%b mode=%0d, required none", if0.out_bit, if0.out_mode);
        end else if (if0.out_bit !== e[q] || if0.out_mode !== m[q]) begin
          n_fail++;
          $display("FAIL bp_order[%0d]: bit=%b mode=%0d, required bit=%b mode=%0d",
                   q, if0.out_bit, if0.out_mode, e[q], m[q]);
        end
        q++;
      end
      step();
    end
    n_chk++;
    if (q !== 4) begin
      n_fail++;
      $display("FAIL bp_count: received %0d results, required 4", q);
    end
  endtask
  task automatic test_bubbles();
    logic ev;
    for (int c = 0; c < 10; c++) begin
      if0.in_valid = (c == 0 || c == 2);
      if0.in_data = $urandom;
      if0.in_mode = 2'($urandom_range(0, 3));
      step();
      ev = (c == 4 || c == 6);
      n_chk++;
      if (if0.out_valid !== ev) begin
        n_fail++;
        $display("FAIL bubble[c%0d]: out_valid=%b required %b", c + 1, if0.out_valid, ev);
      end
    end
  endtask
  task automatic test_reset_midflight();
    if0.in_valid = 0; if0.in_data = '0; if0.in_mode = 2'd3;
    repeat (6) step();
    for (int c = 0; c < 3; c++) begin
      if0.in_valid = 1;
      rst = (c == 2);
      step();
    end
    rst = 0;
    if0.in_valid = 0;
    n_chk++;
    if (if0.out_valid !== 1'b0 || if0.out_bit !== 1'b0 || if0.out_mode !== 2'd0 || if0.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset: valid=%b bit=%b mode=%0d in_ready=%b, required 0 0 0 1",
               if0.out_valid, if0.out_bit, if0.out_mode, if0.in_ready);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      n_chk++;
      if (if0.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_flush[c%0d]: out_valid=%b required 0", c, if0.out_valid);
      end
    end
  endtask
  task automatic test_sweep();
    int          lat [3] = '{2, 1, 1};
    int          wid [3] = '{8, 64, 2};
    logic        hv [202];
    logic [1:0]  hm [202];
    logic        hb [3][202];
    logic        ov [3];
    logic        ob [3];
    logic [1:0]  om [3];
    logic [63:0] r;
    logic [1:0]  md;
    logic        v, ev;
    int i;
    for (int c = 0; c < 202; c++) begin
      r  = {$urandom, $urandom};
      md = 2'($urandom_range(0, 3));
      v  = (c < 200) && ($urandom_range(0, 3) != 0);
      hv[c] = v;
      hm[c] = md;
      for (int k = 0; k < 3; k++) hb[k][c] = ref_bit(r, wid[k], md);
      if1.in_valid = v; if1.in_data = r[7:0]; if1.in_mode = md;
      if2.in_valid = v; if2.in_data = r;      if2.in_mode = md;
      if3.in_valid = v; if3.in_data = r[1:0]; if3.in_mode = md;
      step();
      ov = '{if1.out_valid, if2.out_valid, if3.out_valid};
      ob = '{if1.out_bit, if2.out_bit, if3.out_bit};
      om = '{if1.out_mode, if2.out_mode, if3.out_mode};
      for (int k = 0; k < 3; k++) begin
        i = c + 1 - lat[k];
        ev = 1'b0;
        if (i >= 0) ev = hv[i];
        n_chk++;
        if (ov[k] !== ev || (ev && (ob[k] !== hb[k][i] || om[k] !== hm[i]))) begin
          n_fail++;
          $display("FAIL sweep[w%0d c%0d]: valid=%b bit=%b mode=%0d, required valid=%b bit=%b mode=%0d",
                   wid[k], c + 1, ov[k], ob[k], om[k], ev, ev ? hb[k][i] : 1'b0, ev ? hm[i] : 2'd0);
        end
      end
    end
  endtask
  initial begin
    idle();
    test_reset();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_bubbles();
    test_reset_midflight();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
